// File: rtl/result_uart_tx.sv
// UART 8N1 transmitter for the calculator result: on a start rise it sends the
// four latched digits as ASCII hex, followed by CR LF.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [3:0] d3_i,
    input  logic [3:0] d2_i,
    input  logic [3:0] d1_i,
    input  logic [3:0] d0_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);
    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic          start_q;
    logic [15:0]   digits_q;
    logic [2:0]    byte_idx_q;
    logic [2:0]    bit_idx_q;
    logic [BW-1:0] baud_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;

    logic          start_rise;
    logic          bit_end;
    logic [7:0]    cur_byte;

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        // 'A' - 10 == 8'h37, so digits 10..15 land on 'A'..'F'
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign start_rise = start_i & ~start_q;
    assign bit_end    = (baud_q == BAUD_LAST);

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx_q)
            3'd0:    cur_byte = to_ascii(digits_q[15:12]);
            3'd1:    cur_byte = to_ascii(digits_q[11:8]);
            3'd2:    cur_byte = to_ascii(digits_q[7:4]);
            3'd3:    cur_byte = to_ascii(digits_q[3:0]);
            3'd4:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            start_q    <= 1'b1;
            digits_q   <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q <= start_i;
            done_q  <= 1'b0;
            if (state_q != IDLE)
                baud_q <= bit_end ? '0 : baud_q + 1'b1;
            case (state_q)
                IDLE: begin
                    // A rise landing on the done cycle is dropped, not deferred
                    if (start_rise && !done_q) begin
                        digits_q   <= {d3_i, d2_i, d1_i, d0_i};
                        byte_idx_q <= '0;
                        baud_q     <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q      <= cur_byte[0];
                        shreg_q   <= {1'b0, cur_byte[7:1]};
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tx_q      <= shreg_q[0];
                            shreg_q   <= {1'b0, shreg_q[7:1]};
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (byte_idx_q < 3'd5) begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            tx_q       <= 1'b0;
                            state_q    <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Randomized bench for result_uart_tx: per-cycle capture of the line compared
// against an ideal 8N1 waveform built from the digits accepted at start.
module tb_result_uart_tx;
    localparam int CPB   = 4;
    localparam int FRAME = 60 * CPB;
    localparam int NCAP  = FRAME + 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] d3, d2, d1, d0;
    logic       tx, busy, done;

    int checks   = 0;
    int failures = 0;

    logic cap_tx   [0:399];
    logic cap_busy [0:399];
    logic cap_done [0:399];
    int   exp_tx   [0:FRAME-1];
    int   exp_byte [0:5];

    result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .start_i(start),
        .d3_i(d3), .d2_i(d2), .d1_i(d1), .d0_i(d0),
        .tx_o(tx), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ascii(input int n);
        return (n < 10) ? (48 + n) : (65 + n - 10);
    endfunction

    // Ideal line: per byte, start 0, 8 data bits LSB first, stop 1, CPB clocks each
    function automatic void build_model(input int a, input int b, input int c, input int e);
        exp_byte[0] = ascii(a); exp_byte[1] = ascii(b);
        exp_byte[2] = ascii(c); exp_byte[3] = ascii(e);
        exp_byte[4] = 13;       exp_byte[5] = 10;
        for (int k = 0; k < 6; k++)
            for (int bit_n = 0; bit_n < 10; bit_n++)
                for (int j = 0; j < CPB; j++)
                    exp_tx[(k*10 + bit_n)*CPB + j] =
                        (bit_n == 0) ? 0 : (bit_n == 9) ? 1 : ((exp_byte[k] >> (bit_n-1)) & 1);
    endfunction

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_tx[i] = tx; cap_busy[i] = busy; cap_done[i] = done;
        end
    endtask

    task automatic count_range(input int lo, input int hi, output int nb, output int nd, output int nl);
        nb = 0; nd = 0; nl = 0;
        for (int i = lo; i <= hi; i++) begin
            nb += int'(cap_busy[i]); nd += int'(cap_done[i]); nl += int'(!cap_tx[i]);
        end
    endtask

    task automatic verify_frame(input string tag);
        int mism, nb, nd, nl, got;
        chk({tag, "_pre_tx"}, cap_tx[0], 1);
        chk({tag, "_pre_busy"}, cap_busy[0], 0);
        mism = 0;
        for (int i = 0; i < FRAME; i++) if (cap_tx[i+1] !== exp_tx[i][0]) mism++;
        chk({tag, "_wave_mism"}, mism, 0);
        for (int k = 0; k < 6; k++) begin
            got = 0;
            for (int i = 0; i < 8; i++)
                got |= int'(cap_tx[1 + (k*10 + 1 + i)*CPB + CPB/2]) << i;
            chk($sformatf("%s_byte%0d", tag, k), got, exp_byte[k]);
        end
        count_range(0, FRAME + 1, nb, nd, nl);
        chk({tag, "_busy_cnt"}, nb, FRAME);
        chk({tag, "_done_cnt"}, nd, 1);
        chk({tag, "_done_pos"}, cap_done[FRAME+1], 1);
        chk({tag, "_end_tx"}, cap_tx[FRAME+1], 1);
    endtask

    // mode 0: 1-clk pulse; 1: held + second rise + digit churn;
    // 2: extra rise on the done cycle; 3: extra rise one clock after done
    task automatic run_frame(input string tag, input int mode);
        int nb, nd, nl;
        build_model(d3, d2, d1, d0);
        start = 1'b1;
        fork
            capture(NCAP);
            begin
                @(posedge clk); #1;
                case (mode)
                    1: begin
                        repeat (40) @(posedge clk); #1;
                        {d3, d2, d1, d0} = 16'($urandom);
                        repeat (60) @(posedge clk); #1;
                        start = 1'b0;
                        @(posedge clk); #1;
                        start = 1'b1;
                        {d3, d2, d1, d0} = 16'($urandom);
                        repeat (50) @(posedge clk); #1;
                        start = 1'b0;
                    end
                    2: begin
                        start = 1'b0;
                        repeat (FRAME) @(posedge clk); #1;
                        start = 1'b1;
                        repeat (5) @(posedge clk); #1;
                        start = 1'b0;
                    end
                    3: begin
                        start = 1'b0;
                        repeat (FRAME + 1) @(posedge clk); #1;
                        start = 1'b1;
                        @(posedge clk); #1;
                        start = 1'b0;
                    end
                    default: start = 1'b0;
                endcase
            end
        join
        verify_frame(tag);
        if (mode == 3) begin
            chk({tag, "_relaunch_pre"}, cap_tx[FRAME+2], 1);
            chk({tag, "_relaunch_tx"}, cap_tx[FRAME+3], 0);
            chk({tag, "_relaunch_busy"}, cap_busy[FRAME+3], 1);
            repeat (FRAME + 10) @(posedge clk);
        end else begin
            count_range(FRAME + 2, NCAP - 1, nb, nd, nl);
            chk({tag, "_tail_busy"}, nb, 0);
            chk({tag, "_tail_txlow"}, nl, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int nb, nd, nl;
        rst = 1'b0; start = 1'b1; {d3, d2, d1, d0} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        capture(20);
        count_range(0, 19, nb, nd, nl);
        chk("held_busy", nb, 0);
        chk("held_txlow", nl, 0);
        chk("held_done", nd, 0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk); #1;

        {d3, d2, d1, d0} = {4'd3, 4'd2, 4'd0, 4'd5};
        run_frame("f3205", 0);
        {d3, d2, d1, d0} = {4'd9, 4'd9, 4'd14, 4'd14};
        run_frame("f99EE", 0);
        {d3, d2, d1, d0} = {4'd10, 4'd15, 4'd10, 4'd15};
        run_frame("fAFAF", 0);
        for (int r = 0; r < 4; r++) begin
            {d3, d2, d1, d0} = 16'($urandom);
            run_frame($sformatf("rnd%0d", r), 0);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end

        {d3, d2, d1, d0} = 16'($urandom);
        run_frame("held", 1);

        {d3, d2, d1, d0} = 16'($urandom);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (94) @(posedge clk); #1;
        chk("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        capture(30);
        count_range(0, 29, nb, nd, nl);
        chk("post_rst_busy", nb, 0);
        chk("post_rst_done", nd, 0);
        chk("post_rst_txlow", nl, 0);
        @(posedge clk); #1;

        {d3, d2, d1, d0} = 16'($urandom);
        run_frame("done_edge", 2);
        {d3, d2, d1, d0} = 16'($urandom);
        run_frame("after_done", 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
